uart_psram_bridge: RTL
======================

# uart_psram_bridge

Command front-end between the UART receiver/transmitter and the PSRAM controller. It assembles UART bytes into read/write command frames, issues one strobe per frame to the PSRAM controller, and streams the result back over UART: a 16-bit read word, a write acknowledge, or a NACK. Each byte-wise command is timed out and validated, so a partial or garbled frame never reaches the PSRAM.

## Interface
- `TIMEOUT_CYC`, 50000 — inter-byte timeout in `clk` cycles; a partial frame is abandoned after this many idle cycles.
- `ACK_BYTE`, 8'hA5 — byte returned after a completed write.
- `NACK_BYTE`, 8'hEE — byte returned for an illegal opcode.
- `clk` in 1 — single system clock; all logic is on its rising edge.
- `arst` in 1 — asynchronous, active-high reset.
- `rx_valid` in 1 — UART receive byte available.
- `rx_data` in 8 — UART receive byte; valid while `rx_valid` is high.
- `rx_read` out 1 — consume pulse; high in every cycle in which `rx_valid` is high.
- `tx_busy` in 1 — UART transmitter busy.
- `tx_write` out 1 — one-cycle transmit request.
- `tx_data` out 8 — byte to transmit; valid while `tx_write` is high.
- `psram_stb` out 1 — one-cycle command strobe to the PSRAM controller.
- `psram_we` out 1 — 1 = write, 0 = read; valid with `psram_stb`.
- `psram_addr` out 24 — PSRAM address.
- `psram_din` out 16 — PSRAM write data.
- `psram_busy` in 1 — PSRAM controller busy.
- `psram_rdat` in 16 — PSRAM read data; valid when `psram_busy` falls.
- `frame_err` out 1 — one-cycle pulse on timeout, illegal opcode, or a byte dropped while busy.
- `bridge_busy` out 1 — high in every state except IDLE.

## Operation
- Frame layout:
  - byte0 = opcode: 0x00 read, 0x01 write.
  - bytes 1..3 = address, LSB first: `psram_addr = {b3,b2,b1}`.
  - Write frames only: bytes 4..5 = data, LSB first: `psram_din = {b5,b4}`.
- States: IDLE, ADDR, DATA, ISSUE, ARM, WAIT, RESP.
- IDLE:
  - Byte 0x00 or 0x01: latch it as the opcode and go to ADDR.
  - Any other byte: pulse `frame_err`, queue `NACK_BYTE`, go to RESP.
- ADDR: collect 3 bytes. Read → ISSUE; write → DATA.
- DATA: collect 2 bytes, then go to ISSUE.
- ISSUE: drive `psram_stb`=1 and `psram_we`=opcode[0] for exactly one cycle, then go to ARM.
- ARM: one cycle in which `psram_busy` is ignored, covering the controller's busy-assert latency. Then go to WAIT.
- WAIT: exit in the first cycle `psram_busy`==0.
  - Read: capture `psram_rdat` that cycle and queue two bytes, `rdat[15:8]` then `rdat[7:0]`.
  - Write: queue `ACK_BYTE`.
  - Go to RESP.
- RESP: hand out the queued bytes. Return to IDLE in the cycle after the last `tx_write`.
- `psram_addr` and `psram_din` hold their latched values from ISSUE until the next frame overwrites them. Neither changes during ARM or WAIT.
- Timeout counter:
  - Counts `clk` cycles in ADDR and DATA; clears on every accepted byte.
  - On reaching `TIMEOUT_CYC`-1: pulse `frame_err`, discard the frame, go to IDLE. No strobe and no UART response.
- Bytes arriving in ISSUE, ARM, WAIT or RESP are consumed (`rx_read`), dropped, and flagged with a `frame_err` pulse. The state is unchanged.

## Timing
- Reset (`arst`=1):
  - All outputs are 0 immediately, asynchronously: `psram_stb`, `psram_we`, `tx_write`, `tx_data`, `psram_addr`, `psram_din`, `frame_err`, `bridge_busy`, `rx_read`.
  - The state returns to IDLE, the queue empties and the timeout counter clears.
  - Reset in the middle of a frame or a PSRAM access abandons it; no response is sent.
- `rx_read` is combinational: `rx_read` = `rx_valid`.
- Strobe latency: `psram_stb` rises 1 cycle after the last frame byte is accepted.
- Response latency: the first `tx_write` occurs no earlier than 1 cycle after the WAIT exit.
- `tx_write` handshake:
  - Asserted only when `tx_busy`==0 and a byte is queued.
  - After each `tx_write`, one holdoff cycle follows during which `tx_write` stays low, regardless of `tx_busy`. This covers the transmitter's busy-assert latency.
- Consecutive frames: the next opcode byte is accepted in the first IDLE cycle after RESP.
- Timeout boundary:
  - A byte arriving in the same cycle the counter reaches `TIMEOUT_CYC`-1 is accepted, and the timeout does not fire.
- `frame_err` pulse rules:
  - At most one `frame_err` pulse per cycle.
  - An illegal opcode and a drop cannot occur in the same cycle.

## Test plan
- Write frame 01 56 34 12 CD AB:
  - One `psram_stb` with `psram_we`=1, addr=0x123456, din=0xABCD.
  - Hold busy for 10 cycles, then release → exactly one `tx_write` with 0xA5.
- Read frame 00 10 00 00, controller returns rdat=0xBEEF:
  - `psram_stb` with `psram_we`=0, addr=0x000010.
  - `tx_data` sequence 0xBE then 0xEF, each sent only while `tx_busy`=0.
- Opcode 0x7F → `frame_err` pulse, single `tx_write` of 0xEE, no `psram_stb`.
- With `TIMEOUT_CYC`=100, send 01 11 22 then stop → `frame_err` at cycle 99 after the last byte, no strobe; a following read frame completes normally.
- Send byte 0x55 during WAIT → `rx_read` pulse, `frame_err` pulse, read response still 2 correct bytes.
- Assert `arst` during WAIT → all outputs 0 at once; after release, a read frame succeeds with no stale transmit.

Source files
------------

// File: rtl/uart_psram_bridge_if.sv
// uart_psram_bridge_if: UART byte stream and PSRAM command signals around the bridge.
interface uart_psram_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_read;
  logic        tx_busy;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        psram_stb;
  logic        psram_we;
  logic [23:0] psram_addr;
  logic [15:0] psram_din;
  logic        psram_busy;
  logic [15:0] psram_rdat;
  logic        frame_err;
  logic        bridge_busy;
  modport master(
    input  rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    output rx_read, tx_write, tx_data, psram_stb, psram_we, psram_addr, psram_din, frame_err, bridge_busy
  );
  modport slave(
    output rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    input  rx_read, tx_write, tx_data, psram_stb, psram_we, psram_addr, psram_din, frame_err, bridge_busy
  );
endinterface

// File: rtl/uart_psram_bridge.sv
// uart_psram_bridge: assembles UART command frames into single PSRAM strobes and
// streams back the read word, a write ACK or a NACK.
module uart_psram_bridge #(
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5,
  parameter logic [7:0]  NACK_BYTE   = 8'hEE
) (
  input logic clk,
  input logic arst,
  uart_psram_bridge_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, ARM, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        bcnt_q, bcnt_d, qn_q, qn_d;
  logic              op_q, op_d, ho_q, ho_d;
  logic [4:0][7:0]   fb_q, fb_d;
  logic [23:0]       addr_q, addr_d;
  logic [15:0]       din_q, din_d, q_q, q_d;
  logic [2:0]        idx;
  logic              collect, take, last, expire, tx_go;
  always_comb begin
    collect = state_q == ADDR || state_q == DATA;
    take    = collect && bus.rx_valid;
    last    = take && bcnt_q == (state_q == ADDR ? 2'd2 : 2'd1);
    expire  = collect && !bus.rx_valid && cnt_q == CW'(TIMEOUT_CYC - 1);
    tx_go   = state_q == RESP && qn_q != 2'd0 && !bus.tx_busy && !ho_q;
    idx     = state_q == DATA ? {1'b0, bcnt_q} + 3'd3 : {1'b0, bcnt_q};
    state_d = state_q;
    // the count reads 1 in the cycle after a byte, so it equals the idle cycles since that byte
    cnt_d   = take ? CW'(1) : collect ? cnt_q + CW'(1) : '0;
    bcnt_d  = last ? 2'd0 : take ? bcnt_q + 2'd1 : bcnt_q;
    op_d    = op_q;
    fb_d    = fb_q;
    if (take) fb_d[idx] = bus.rx_data;
    addr_d  = addr_q;
    din_d   = din_q;
    q_d     = tx_go ? {q_q[7:0], 8'h00} : q_q;
    qn_d    = tx_go ? qn_q - 2'd1 : qn_q;
    ho_d    = tx_go;
    case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data[7:1] == 7'd0) begin
          op_d    = bus.rx_data[0];
          cnt_d   = CW'(1);
          bcnt_d  = 2'd0;
          state_d = ADDR;
        end else begin
          q_d     = {NACK_BYTE, 8'h00};
          qn_d    = 2'd1;
          state_d = RESP;
        end
      end
      ADDR:  state_d = expire ? IDLE : last ? (op_q ? DATA : ISSUE) : ADDR;
      DATA:  state_d = expire ? IDLE : last ? ISSUE : DATA;
      ISSUE: state_d = ARM;
      ARM:   state_d = WAIT;
      WAIT: if (!bus.psram_busy) begin
        q_d     = op_q ? {ACK_BYTE, 8'h00} : bus.psram_rdat;
        qn_d    = op_q ? 2'd1 : 2'd2;
        state_d = RESP;
      end
      RESP:  state_d = tx_go && qn_q == 2'd1 ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (last && state_d == ISSUE) begin
      addr_d = {fb_d[2], fb_d[1], fb_d[0]};
      din_d  = op_q ? {fb_d[4], fb_d[3]} : din_q;
    end
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= 2'd0;
      qn_q    <= 2'd0;
      op_q    <= 1'b0;
      ho_q    <= 1'b0;
      fb_q    <= '0;
      addr_q  <= 24'h0;
      din_q   <= 16'h0;
      q_q     <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      qn_q    <= qn_d;
      op_q    <= op_d;
      ho_q    <= ho_d;
      fb_q    <= fb_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      q_q     <= q_d;
    end
  end
  assign bus.rx_read     = bus.rx_valid && !arst;
  assign bus.frame_err   = !arst && (expire || (bus.rx_valid && (state_q == IDLE ? bus.rx_data[7:1] != 7'd0 : !collect)));
  assign bus.tx_write    = tx_go;
  assign bus.tx_data     = q_q[15:8];
  assign bus.psram_stb   = state_q == ISSUE;
  assign bus.psram_we    = state_q == ISSUE && op_q;
  assign bus.psram_addr  = addr_q;
  assign bus.psram_din   = din_q;
  assign bus.bridge_busy = state_q != IDLE;
endmodule
